// File: rtl/ir_nec_pkg.sv
// Shared definitions for the NEC IR receive path: FSM encoding, error codes
// and pulse timing windows in microseconds (inclusive bounds).
package ir_nec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LEAD_MARK  = 3'd1,
        ST_LEAD_SPACE = 3'd2,
        ST_BIT_MARK   = 3'd3,
        ST_BIT_SPACE  = 3'd4,
        ST_STOP_MARK  = 3'd5
    } state_t;

    localparam logic [1:0] ERR_TIMING  = 2'd1;
    localparam logic [1:0] ERR_CMPL    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [15:0] LEAD_MARK_MIN  = 16'd8000;
    localparam logic [15:0] LEAD_MARK_MAX  = 16'd10000;
    localparam logic [15:0] DATA_SPACE_MIN = 16'd4000;
    localparam logic [15:0] DATA_SPACE_MAX = 16'd5000;
    localparam logic [15:0] RPT_SPACE_MIN  = 16'd1900;
    localparam logic [15:0] RPT_SPACE_MAX  = 16'd2600;
    localparam logic [15:0] BIT_MARK_MIN   = 16'd400;
    localparam logic [15:0] BIT_MARK_MAX   = 16'd700;
    localparam logic [15:0] ZERO_SPACE_MIN = 16'd400;
    localparam logic [15:0] ZERO_SPACE_MAX = 16'd700;
    localparam logic [15:0] ONE_SPACE_MIN  = 16'd1400;
    localparam logic [15:0] ONE_SPACE_MAX  = 16'd1900;
    localparam logic [15:0] TIMEOUT_US     = 16'd12000;
    localparam logic [15:0] WIDTH_MAX      = 16'hFFFF;

    function automatic logic in_win(input logic [15:0] w,
                                    input logic [15:0] lo,
                                    input logic [15:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// Free-running 1 us enable generator; one clk-wide pulse every CLK_HZ/1e6 cycles.
module ir_tick_gen #(
    parameter int CLK_HZ = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_1us
);

    localparam int DIV = CLK_HZ / 1000000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;

    // Divider counter and registered tick pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= '0;
            tick_1us <= 1'b0;
        end else begin
            if (cnt_r == LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
            tick_1us <= (cnt_r == LAST);
        end
    end

endmodule

// File: rtl/ir_nec_rx_param.sv
// Parametrised NEC IR receiver: synchronised input, 1 us timebase, windowed
// pulse FSM with complement checks, repeat-frame handling and error strobes.
module ir_nec_rx_param
    import ir_nec_pkg::*;
#(
    parameter int CLK_HZ        = 50000000,
    parameter int RX_INV        = 1,
    parameter int CHECK_CMD     = 1,
    parameter int CHECK_ADDR    = 0,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_WIN_US = 110000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_ir_rx,
    output logic [31:0] o_data,
    output logic        o_valid,
    output logic        o_repeat,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    output logic        o_busy
);

    localparam logic [16:0] RPT_WIN = 17'(REPEAT_WIN_US);

    logic        rx_fix_s, rx_meta_r, rx_sync_r, mark_prev_r;
    logic        rise_s, fall_s, tick_s;
    logic [15:0] width_r;
    logic [16:0] rpt_tmr_r;
    state_t      state_r, state_nx;
    logic [31:0] shift_r, shift_nx;
    logic [5:0]  bit_cnt_r, bit_cnt_nx;
    logic        is_rpt_r, is_rpt_nx, have_frame_r;
    logic        bit_zero_s, bit_one_s, mark_ok_s, cmd_ok_s, addr_ok_s;
    logic        ev_valid_s, ev_repeat_s, ev_err_s;
    logic [1:0]  ev_code_s;
    logic [31:0] data_r;
    logic        valid_r, repeat_r, err_r, busy_r;
    logic [1:0]  err_code_r;

    ir_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_1us (tick_s)
    );

    // Polarity is fixed ahead of the synchroniser so its reset value (0) is the idle space level.
    assign rx_fix_s = (RX_INV != 0) ? ~i_ir_rx : i_ir_rx;
    assign rise_s   = rx_sync_r & ~mark_prev_r;
    assign fall_s   = ~rx_sync_r & mark_prev_r;

    assign bit_zero_s = in_win(width_r, ZERO_SPACE_MIN, ZERO_SPACE_MAX);
    assign bit_one_s  = in_win(width_r, ONE_SPACE_MIN, ONE_SPACE_MAX);
    assign mark_ok_s  = in_win(width_r, BIT_MARK_MIN, BIT_MARK_MAX);
    assign cmd_ok_s   = (CHECK_CMD == 0) || (shift_r[31:24] == ~shift_r[23:16]);
    assign addr_ok_s  = (CHECK_ADDR == 0) || (shift_r[15:8] == ~shift_r[7:0]);

    // Two-flop synchroniser plus previous-value flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r   <= 1'b0;
            rx_sync_r   <= 1'b0;
            mark_prev_r <= 1'b0;
        end else begin
            rx_meta_r   <= rx_fix_s;
            rx_sync_r   <= rx_meta_r;
            mark_prev_r <= rx_sync_r;
        end
    end

    // Pulse width in us since the last edge; the edge cycle still sees the finished width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_r <= 16'd0;
        end else if (rise_s || fall_s) begin
            width_r <= 16'd0;
        end else if (tick_s && (width_r != WIDTH_MAX)) begin
            width_r <= width_r + 16'd1;
        end else begin
            width_r <= width_r;
        end
    end

    // Next-state, shift register and strobe-event decode.
    always_comb begin
        state_nx    = state_r;
        shift_nx    = shift_r;
        bit_cnt_nx  = bit_cnt_r;
        is_rpt_nx   = is_rpt_r;
        ev_valid_s  = 1'b0;
        ev_repeat_s = 1'b0;
        ev_err_s    = 1'b0;
        ev_code_s   = ERR_TIMING;
        if ((state_r != ST_IDLE) && (width_r >= TIMEOUT_US)) begin
            ev_err_s  = 1'b1;
            ev_code_s = ERR_TIMEOUT;
            state_nx  = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rise_s) state_nx = ST_LEAD_MARK;
                    else        state_nx = ST_IDLE;
                end
                ST_LEAD_MARK: begin
                    if (!fall_s) begin
                        state_nx = ST_LEAD_MARK;
                    end else if (in_win(width_r, LEAD_MARK_MIN, LEAD_MARK_MAX)) begin
                        state_nx = ST_LEAD_SPACE;
                    end else begin
                        ev_err_s = 1'b1;
                        state_nx = ST_IDLE;
                    end
                end
                ST_LEAD_SPACE: begin
                    if (!rise_s) begin
                        state_nx = ST_LEAD_SPACE;
                    end else if (in_win(width_r, DATA_SPACE_MIN, DATA_SPACE_MAX)) begin
                        bit_cnt_nx = 6'd0;
                        is_rpt_nx  = 1'b0;
                        state_nx   = ST_BIT_MARK;
                    end else if ((REPEAT_EN != 0) && in_win(width_r, RPT_SPACE_MIN, RPT_SPACE_MAX)) begin
                        is_rpt_nx = 1'b1;
                        state_nx  = ST_STOP_MARK;
                    end else begin
                        ev_err_s = 1'b1;
                        state_nx = ST_IDLE;
                    end
                end
                ST_BIT_MARK: begin
                    if (!fall_s)        state_nx = ST_BIT_MARK;
                    else if (mark_ok_s) state_nx = ST_BIT_SPACE;
                    else begin
                        ev_err_s = 1'b1;
                        state_nx = ST_IDLE;
                    end
                end
                ST_BIT_SPACE: begin
                    if (!rise_s) begin
                        state_nx = ST_BIT_SPACE;
                    end else if (bit_zero_s || bit_one_s) begin
                        shift_nx   = {bit_one_s, shift_r[31:1]};
                        bit_cnt_nx = bit_cnt_r + 6'd1;
                        if (bit_cnt_r == 6'd31) state_nx = ST_STOP_MARK;
                        else                    state_nx = ST_BIT_MARK;
                    end else begin
                        ev_err_s = 1'b1;
                        state_nx = ST_IDLE;
                    end
                end
                ST_STOP_MARK: begin
                    if (!fall_s) begin
                        state_nx = ST_STOP_MARK;
                    end else begin
                        state_nx = ST_IDLE;
                        if (!mark_ok_s) begin
                            ev_err_s = 1'b1;
                        end else if (is_rpt_r) begin
                            ev_repeat_s = have_frame_r && (rpt_tmr_r < RPT_WIN);
                        end else if (cmd_ok_s && addr_ok_s) begin
                            ev_valid_s = 1'b1;
                        end else begin
                            ev_err_s  = 1'b1;
                            ev_code_s = ERR_CMPL;
                        end
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // FSM and datapath state registers, repeat timer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            shift_r      <= 32'd0;
            bit_cnt_r    <= 6'd0;
            is_rpt_r     <= 1'b0;
            have_frame_r <= 1'b0;
            rpt_tmr_r    <= 17'd0;
            data_r       <= 32'd0;
            valid_r      <= 1'b0;
            repeat_r     <= 1'b0;
            err_r        <= 1'b0;
            err_code_r   <= 2'd0;
            busy_r       <= 1'b0;
        end else begin
            state_r   <= state_nx;
            shift_r   <= shift_nx;
            bit_cnt_r <= bit_cnt_nx;
            is_rpt_r  <= is_rpt_nx;
            valid_r   <= ev_valid_s;
            repeat_r  <= ev_repeat_s;
            err_r     <= ev_err_s;
            busy_r    <= (state_nx != ST_IDLE);
            if (ev_err_s) err_code_r <= ev_code_s;
            if (ev_valid_s) begin
                data_r       <= shift_r;
                have_frame_r <= 1'b1;
            end
            if (ev_valid_s || ev_repeat_s) begin
                rpt_tmr_r <= 17'd0;
            end else if (tick_s && (rpt_tmr_r != 17'h1FFFF)) begin
                rpt_tmr_r <= rpt_tmr_r + 17'd1;
            end else begin
                rpt_tmr_r <= rpt_tmr_r;
            end
        end
    end

    assign o_data     = data_r;
    assign o_valid    = valid_r;
    assign o_repeat   = repeat_r;
    assign o_err      = err_r;
    assign o_err_code = err_code_r;
    assign o_busy     = busy_r;

endmodule

// File: tb/tb_ir_nec_rx_param.sv
// Directed bench: two receivers (command check on/off) share one IR pin;
// 1 MHz clock so one cycle equals one microsecond.
module tb_ir_nec_rx_param;

    localparam int K_DATA = 0, K_REPEAT = 1, K_LEAD_ONLY = 2, K_BAD_BIT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ir;
    logic [31:0] o_data0, o_data1;
    logic        o_valid0, o_valid1, o_repeat0, o_repeat1, o_err0, o_err1, o_busy0, o_busy1;
    logic [1:0]  o_err_code0, o_err_code1;

    int n_checks = 0, n_err = 0;
    int v0_cnt = 0, r0_cnt = 0, e0_cnt = 0, v1_cnt = 0, r1_cnt = 0, e1_cnt = 0;
    int excl_viol = 0, data_viol = 0;
    logic [31:0] d0_prev = 32'd0, d1_prev = 32'd0;

    always #1 clk = ~clk;

    ir_nec_rx_param #(.CLK_HZ(1000000), .RX_INV(1), .CHECK_CMD(1), .CHECK_ADDR(0),
                      .REPEAT_EN(1), .REPEAT_WIN_US(110000)) u0 (
        .clk(clk), .rst_n(rst_n), .i_ir_rx(ir), .o_data(o_data0), .o_valid(o_valid0),
        .o_repeat(o_repeat0), .o_err(o_err0), .o_err_code(o_err_code0), .o_busy(o_busy0));

    ir_nec_rx_param #(.CLK_HZ(1000000), .RX_INV(1), .CHECK_CMD(0), .CHECK_ADDR(0),
                      .REPEAT_EN(1), .REPEAT_WIN_US(110000)) u1 (
        .clk(clk), .rst_n(rst_n), .i_ir_rx(ir), .o_data(o_data1), .o_valid(o_valid1),
        .o_repeat(o_repeat1), .o_err(o_err1), .o_err_code(o_err_code1), .o_busy(o_busy1));

    // Strobe counters plus exclusivity and data-stability watchers.
    always @(negedge clk) begin
        if (o_valid0)  v0_cnt <= v0_cnt + 1;
        if (o_repeat0) r0_cnt <= r0_cnt + 1;
        if (o_err0)    e0_cnt <= e0_cnt + 1;
        if (o_valid1)  v1_cnt <= v1_cnt + 1;
        if (o_repeat1) r1_cnt <= r1_cnt + 1;
        if (o_err1)    e1_cnt <= e1_cnt + 1;
        if (($countones({o_valid0, o_repeat0, o_err0}) > 1) ||
            ($countones({o_valid1, o_repeat1, o_err1}) > 1))
            excl_viol <= excl_viol + 1;
        if (rst_n && (((o_data0 != d0_prev) && !o_valid0) || ((o_data1 != d1_prev) && !o_valid1)))
            data_viol <= data_viol + 1;
        d0_prev <= o_data0;
        d1_prev <= o_data1;
    end

    typedef struct {
        int          kind;
        int          gap_us;
        int          lead_us;
        logic [31:0] data;
        int          bad_bit;
        int          bad_us;
        int          nv0, nr0, ne0;
        logic [1:0]  code0;
        logic [31:0] data0;
        int          nv1, nr1, ne1;
        logic [1:0]  code1;
        logic [31:0] data1;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Pin is active-low: a mark drives it to 0.
    task automatic drive(input logic mark, input int us);
        ir = ~mark;
        repeat (us) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] d, input int nbits, input int bad_bit, input int bad_us);
        for (int i = 0; i < nbits; i++) begin
            drive(1'b1, 560);
            drive(1'b0, (i == bad_bit) ? bad_us : (d[i] ? 1690 : 560));
        end
    endtask

    task automatic send_frame(input logic [31:0] d);
        drive(1'b1, 9000);
        drive(1'b0, 4500);
        send_bits(d, 32, -1, 0);
        drive(1'b1, 560);
        drive(1'b0, 20);
    endtask

    task automatic apply(input vec_t v);
        drive(1'b0, v.gap_us);
        case (v.kind)
            K_REPEAT: begin
                drive(1'b1, 9000);
                drive(1'b0, 2250);
                drive(1'b1, 560);
            end
            K_LEAD_ONLY: drive(1'b1, v.lead_us);
            default: begin
                drive(1'b1, v.lead_us);
                drive(1'b0, 4500);
                send_bits(v.data, (v.kind == K_BAD_BIT) ? 16 : 32, v.bad_bit, v.bad_us);
                drive(1'b1, 560);
            end
        endcase
        drive(1'b0, 20);
    endtask

    initial begin
        int sv0, sr0, se0, sv1, sr1, se1, lat;
        vecs[0] = '{K_REPEAT,    1000,   9000, 32'h0,        -1, 0,    0, 0, 0, 2'd0, 32'h0,        0, 0, 0, 2'd0, 32'h0};
        vecs[1] = '{K_DATA,      1000,   9000, 32'hBA45FF00, -1, 0,    1, 0, 0, 2'd0, 32'hBA45FF00, 1, 0, 0, 2'd0, 32'hBA45FF00};
        vecs[2] = '{K_REPEAT,    40000,  9000, 32'h0,        -1, 0,    0, 1, 0, 2'd0, 32'hBA45FF00, 0, 1, 0, 2'd0, 32'hBA45FF00};
        vecs[3] = '{K_REPEAT,    150000, 9000, 32'h0,        -1, 0,    0, 0, 0, 2'd0, 32'hBA45FF00, 0, 0, 0, 2'd0, 32'hBA45FF00};
        vecs[4] = '{K_DATA,      1000,   9000, 32'hBB45FF00, -1, 0,    0, 0, 1, 2'd2, 32'hBA45FF00, 1, 0, 0, 2'd0, 32'hBB45FF00};
        vecs[5] = '{K_LEAD_ONLY, 1000,   7000, 32'h0,        -1, 0,    0, 0, 1, 2'd1, 32'hBA45FF00, 0, 0, 1, 2'd1, 32'hBB45FF00};
        vecs[6] = '{K_BAD_BIT,   1000,   9000, 32'hBA45FF00, 15, 1000, 0, 0, 1, 2'd1, 32'hBA45FF00, 0, 0, 1, 2'd1, 32'hBB45FF00};
        vecs[7] = '{K_DATA,      1000,   9000, 32'hED12BF40, -1, 0,    1, 0, 0, 2'd1, 32'hED12BF40, 1, 0, 0, 2'd1, 32'hED12BF40};

        ir    = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_data",  o_data0, 32'h0);
        check("reset_valid", {31'd0, o_valid0}, 32'd0);
        check("reset_code",  {30'd0, o_err_code0}, 32'd0);
        check("reset_busy",  {31'd0, o_busy0}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            sv0 = v0_cnt; sr0 = r0_cnt; se0 = e0_cnt;
            sv1 = v1_cnt; sr1 = r1_cnt; se1 = e1_cnt;
            apply(vecs[i]);
            check($sformatf("v%0d_valid0", i),  v0_cnt - sv0, vecs[i].nv0);
            check($sformatf("v%0d_repeat0", i), r0_cnt - sr0, vecs[i].nr0);
            check($sformatf("v%0d_err0", i),    e0_cnt - se0, vecs[i].ne0);
            check($sformatf("v%0d_code0", i),   {30'd0, o_err_code0}, {30'd0, vecs[i].code0});
            check($sformatf("v%0d_data0", i),   o_data0, vecs[i].data0);
            check($sformatf("v%0d_busy0", i),   {31'd0, o_busy0}, 32'd0);
            check($sformatf("v%0d_valid1", i),  v1_cnt - sv1, vecs[i].nv1);
            check($sformatf("v%0d_repeat1", i), r1_cnt - sr1, vecs[i].nr1);
            check($sformatf("v%0d_err1", i),    e1_cnt - se1, vecs[i].ne1);
            check($sformatf("v%0d_code1", i),   {30'd0, o_err_code1}, {30'd0, vecs[i].code1});
            check($sformatf("v%0d_data1", i),   o_data1, vecs[i].data1);
        end

        // Timeout: pin released after the bit-11 mark; the edge reaches the FSM
        // 3 cycles later and the strobe is registered one more cycle on.
        drive(1'b0, 1000);
        drive(1'b1, 9000);
        drive(1'b0, 4500);
        send_bits(32'hBA45FF00, 11, -1, 0);
        drive(1'b1, 560);
        drive(1'b0, 0);
        lat = 0;
        while ((o_err0 !== 1'b1) && (lat < 13000)) begin
            @(negedge clk);
            lat++;
        end
        check("timeout_latency", lat, 12004);
        check("timeout_code0", {30'd0, o_err_code0}, 32'd3);
        check("timeout_code1", {30'd0, o_err_code1}, 32'd3);
        check("timeout_busy",  {31'd0, o_busy0}, 32'd0);
        drive(1'b0, 100);

        // Reset in the middle of the bit-20 mark.
        drive(1'b1, 9000);
        drive(1'b0, 4500);
        send_bits(32'hBA45FF00, 20, -1, 0);
        drive(1'b1, 200);
        check("pre_reset_busy", {31'd0, o_busy0}, 32'd1);
        rst_n = 1'b0;
        drive(1'b0, 5);
        check("midrst_data0",  o_data0, 32'h0);
        check("midrst_data1",  o_data1, 32'h0);
        check("midrst_strobe", {29'd0, o_valid0, o_repeat0, o_err0}, 32'd0);
        check("midrst_code",   {30'd0, o_err_code0}, 32'd0);
        check("midrst_busy",   {31'd0, o_busy0}, 32'd0);
        rst_n = 1'b1;
        sv0 = v0_cnt; se0 = e0_cnt;
        drive(1'b0, 1000);
        check("post_rst_quiet", e0_cnt - se0, 32'd0);
        send_frame(32'hBA45FF00);
        check("post_rst_valid", v0_cnt - sv0, 32'd1);
        check("post_rst_err",   e0_cnt - se0, 32'd0);
        check("post_rst_data",  o_data0, 32'hBA45FF00);

        check("strobe_exclusive", excl_viol, 32'd0);
        check("data_only_with_valid", data_viol, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
